// File: rtl/cond_flag_scheduler_pkg.sv
// Shared definitions for the conditional-issue / flag-writer scheduler:
// condition codes, scheduler state encoding and parameter limits.
package cond_flag_scheduler_pkg;

  // Condition field values that always execute
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Legal upper limits for the scheduler parameters
  localparam int FLAG_LAT_MAX  = 4;
  localparam int BR_SHADOW_MAX = 3;

  // Width of the in-flight writer count (0..FLAG_LAT_MAX)
  localparam int CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sched_state_e;

  // An instruction reads the flags unless its condition is AL or NV
  function automatic logic is_conditional(input logic [3:0] cond);
    return !((cond == COND_AL) || (cond == COND_NV));
  endfunction

endpackage

// File: rtl/cond_flag_scheduler_flag_pending_tracker.sv
// Tracks flag-setting instructions between ID issue and status-register
// writeback as a FLAG_LAT-deep shift register; reports occupancy.
module flag_pending_tracker
  import cond_flag_scheduler_pkg::*;
#(
  parameter int FLAG_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             advance,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);

  logic [FLAG_LAT-1:0] pend;

  generate
    if (FLAG_LAT == 1) begin : g_single
      // Single-stage latency: the writer is visible for exactly one cycle
      always_ff @(posedge clk) begin
        if (rst) begin
          pend <= '0;
        end else if (advance) begin
          pend <= push;
        end
      end
    end else begin : g_multi
      // Each writer walks through FLAG_LAT stages before falling out
      always_ff @(posedge clk) begin
        if (rst) begin
          pend <= '0;
        end else if (advance) begin
          pend <= {pend[FLAG_LAT-2:0], push};
        end
      end
    end
  endgenerate

  // Any set stage means the status register is not yet architecturally valid
  always_comb begin
    busy = |pend;
  end

  // Number of writers still in flight
  always_comb begin
    cnt = '0;
    for (int i = 0; i < FLAG_LAT; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, pend[i]};
    end
  end

endmodule

// File: rtl/cond_flag_scheduler.sv
// ID-stage scheduler: stalls conditional instructions until in-flight
// flag writers have drained, gates issue into an execute enable, and
// flushes IF plus the branch shadow after a taken branch.
// Optional macro COND_SCHED_STATS_EN adds saturating stall/flush counters.
module cond_flag_scheduler
  import cond_flag_scheduler_pkg::*;
#(
  parameter int FLAG_LAT  = 1,
  parameter int BR_SHADOW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             id_valid,
  input  logic [3:0]       id_cond,
  input  logic             id_s,
  input  logic             id_is_branch,
  input  logic             cond_pass,
  output logic             id_issue,
  output logic             exec_en,
  output logic             hazard_stall,
  output logic             branch_taken,
  output logic             if_flush,
  output logic [CNT_W-1:0] pend_cnt
`ifdef COND_SCHED_STATS_EN
  ,
  output logic [15:0]      stall_cycles,
  output logic [15:0]      flush_cycles
`endif
);

  localparam int SH_W = $clog2(BR_SHADOW_MAX);

  sched_state_e    state;
  logic [SH_W-1:0] sh_cnt;
  logic            cond_instr;
  logic            pend_busy;
  logic [CNT_W-1:0] trk_cnt;
  logic            push;
  logic            advance;

  assign cond_instr = is_conditional(id_cond);
  assign push       = id_issue & exec_en & id_s;
  assign advance    = ~freeze;

  flag_pending_tracker #(
    .FLAG_LAT (FLAG_LAT)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .advance (advance),
    .busy    (pend_busy),
    .cnt     (trk_cnt)
  );

  // Reset forces a quiet reset cycle; otherwise expose the live writer count
  assign pend_cnt = rst ? '0 : trk_cnt;

  // Issue decision for the instruction in ID; reset and freeze silence everything
  always_comb begin
    hazard_stall = 1'b0;
    id_issue     = 1'b0;
    exec_en      = 1'b0;
    branch_taken = 1'b0;
    if_flush     = 1'b0;
    if (!rst && !freeze) begin
      if (state == RUN) begin
        hazard_stall = id_valid & cond_instr & pend_busy;
        id_issue     = id_valid & ~hazard_stall;
        exec_en      = id_issue & (~cond_instr | cond_pass);
        branch_taken = exec_en & id_is_branch;
        if_flush     = branch_taken;
      end else begin
        if_flush = 1'b1;
      end
    end
  end

  // Scheduler state: enter FLUSH on a taken branch and count out the shadow slots
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      sh_cnt <= '0;
    end else if (!freeze) begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            state  <= FLUSH;
            sh_cnt <= SH_W'(BR_SHADOW - 1);
          end
        end
        FLUSH: begin
          if (sh_cnt == '0) begin
            state <= RUN;
          end else begin
            sh_cnt <= sh_cnt - 1'b1;
          end
        end
        default: begin
          state  <= RUN;
          sh_cnt <= '0;
        end
      endcase
    end
  end

`ifdef COND_SCHED_STATS_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating occupancy statistics; stall/flush are already 0 while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard_stall && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (if_flush && (flush_q != 16'hFFFF)) begin
        flush_q <= flush_q + 16'd1;
      end
    end
  end

  assign stall_cycles = rst ? 16'd0 : stall_q;
  assign flush_cycles = rst ? 16'd0 : flush_q;
`endif

endmodule

// File: tb/tb_cond_flag_scheduler.sv
// Testbench for cond_flag_scheduler: three parameter sets share one input
// stream; a behavioural model of in-flight writers and flush slots checks
// every instance every cycle, and directed sequences pin known values.
module tb_cond_flag_scheduler;

  localparam int N = 3;
  localparam int FL_P [N] = '{1, 3, 2};
  localparam int BS_P [N] = '{1, 2, 3};
  localparam int SLOTS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_is_branch;
  logic       cond_pass;

  logic       issue_o [N];
  logic       exec_o  [N];
  logic       stall_o [N];
  logic       br_o    [N];
  logic       flush_o [N];
  logic [2:0] pend_o  [N];
`ifdef COND_SCHED_STATS_EN
  logic [15:0] stall_cyc_o [N];
  logic [15:0] flush_cyc_o [N];
`endif

  int checks = 0;
  int passes = 0;

  // Model state: remaining writeback cycles per in-flight writer, flush slots left
  int rem        [N][SLOTS];
  int flush_left [N];
  int stall_cnt  [N];
  int flush_cnt  [N];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      cond_flag_scheduler #(
        .FLAG_LAT  (FL_P[g]),
        .BR_SHADOW (BS_P[g])
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .id_valid     (id_valid),
        .id_cond      (id_cond),
        .id_s         (id_s),
        .id_is_branch (id_is_branch),
        .cond_pass    (cond_pass),
        .id_issue     (issue_o[g]),
        .exec_en      (exec_o[g]),
        .hazard_stall (stall_o[g]),
        .branch_taken (br_o[g]),
        .if_flush     (flush_o[g]),
        .pend_cnt     (pend_o[g])
`ifdef COND_SCHED_STATS_EN
        ,
        .stall_cycles (stall_cyc_o[g]),
        .flush_cycles (flush_cyc_o[g])
`endif
      );
    end
  endgenerate

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] c, input logic s,
                               input logic br, input logic cp, input logic frz,
                               input logic r);
    @(posedge clk);
    #1;
    id_valid     = v;
    id_cond      = c;
    id_s         = s;
    id_is_branch = br;
    cond_pass    = cp;
    freeze       = frz;
    rst          = r;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    #2;
  endtask

  // Reference model and per-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin : compare_proc
    int   e_pend;
    logic e_is, e_ex, e_st, e_br, e_fl, is_cond;
    int   act, exp_v;
    for (int g = 0; g < N; g++) begin
      e_is = 1'b0; e_ex = 1'b0; e_st = 1'b0; e_br = 1'b0; e_fl = 1'b0;
      e_pend = 0;
      for (int k = 0; k < SLOTS; k++) if (rem[g][k] > 0) e_pend++;
`ifdef COND_SCHED_STATS_EN
      checkOutput($sformatf("dut%0d stall_cycles", g), int'(stall_cyc_o[g]), rst ? 0 : stall_cnt[g]);
      checkOutput($sformatf("dut%0d flush_cycles", g), int'(flush_cyc_o[g]), rst ? 0 : flush_cnt[g]);
`endif
      if (rst) begin
        e_pend = 0;
        for (int k = 0; k < SLOTS; k++) rem[g][k] = 0;
        flush_left[g] = 0;
        stall_cnt[g]  = 0;
        flush_cnt[g]  = 0;
      end else if (!freeze) begin
        if (flush_left[g] > 0) begin
          e_fl = 1'b1;
          flush_left[g]--;
        end else begin
          is_cond = (id_cond != 4'hE) && (id_cond != 4'hF);
          e_st = id_valid && is_cond && (e_pend != 0);
          e_is = id_valid && !e_st;
          e_ex = e_is && (!is_cond || cond_pass);
          e_br = e_ex && id_is_branch;
          e_fl = e_br;
          if (e_br) flush_left[g] = BS_P[g];
        end
        for (int k = 0; k < SLOTS; k++) if (rem[g][k] > 0) rem[g][k]--;
        if (e_ex && id_s) begin
          for (int k = 0; k < SLOTS; k++) begin
            if (rem[g][k] == 0) begin
              rem[g][k] = FL_P[g];
              break;
            end
          end
        end
        if (e_st && stall_cnt[g] < 16'hFFFF) stall_cnt[g]++;
        if (e_fl && flush_cnt[g] < 16'hFFFF) flush_cnt[g]++;
      end
      act   = int'({issue_o[g], exec_o[g], stall_o[g], br_o[g], flush_o[g], pend_o[g]});
      exp_v = int'({e_is, e_ex, e_st, e_br, e_fl, 3'(e_pend)});
      checkOutput($sformatf("dut%0d {issue,exec,stall,br,flush,pend}", g), act, exp_v);
    end
  end

  initial begin
    logic       v, s, br, cp, frz, r;
    logic [3:0] c;
    for (int g = 0; g < N; g++) begin
      for (int k = 0; k < SLOTS; k++) rem[g][k] = 0;
      flush_left[g] = 0;
      stall_cnt[g]  = 0;
      flush_cnt[g]  = 0;
    end
    rst = 1'b1; freeze = 1'b0; id_valid = 1'b0; id_cond = 4'hE;
    id_s = 1'b0; id_is_branch = 1'b0; cond_pass = 1'b0;

    // Reset cycle with a live unconditional instruction: everything quiet
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    checkOutput("reset issue", int'(issue_o[0]), 0);
    checkOutput("reset pend_cnt", int'(pend_o[0]), 0);

    // FLAG_LAT=1: ADDS then MOVEQ stalls one cycle
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("adds issue", int'(issue_o[0]), 1);
    checkOutput("adds exec_en", int'(exec_o[0]), 1);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("moveq stall", int'(stall_o[0]), 1);
    checkOutput("moveq stall pend_cnt", int'(pend_o[0]), 1);
    checkOutput("moveq stalled issue", int'(issue_o[0]), 0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("moveq issue", int'(issue_o[0]), 1);
    checkOutput("moveq exec_en", int'(exec_o[0]), 1);
    idle(6);

    // FLAG_LAT=3, BR_SHADOW=2: SUBS, SUBS, BNE
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bne stall c1", int'(stall_o[1]), 1);
    checkOutput("bne pend c1", int'(pend_o[1]), 2);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bne stall c2", int'(stall_o[1]), 1);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bne stall c3", int'(stall_o[1]), 1);
    checkOutput("bne pend c3", int'(pend_o[1]), 1);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("bne branch_taken", int'(br_o[1]), 1);
    checkOutput("bne if_flush", int'(flush_o[1]), 1);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("shadow1 issue", int'(issue_o[1]), 0);
    checkOutput("shadow1 if_flush", int'(flush_o[1]), 1);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("shadow2 issue", int'(issue_o[1]), 0);
    checkOutput("shadow2 if_flush", int'(flush_o[1]), 1);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("post-flush issue", int'(issue_o[1]), 1);
    checkOutput("post-flush if_flush", int'(flush_o[1]), 0);
    idle(6);

    // Conditional S instruction failing its condition leaves no writer
    applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("failed s exec_en", int'(exec_o[0]), 0);
    checkOutput("failed s issue", int'(issue_o[0]), 1);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("after failed s pend", int'(pend_o[0]), 0);
    checkOutput("after failed s stall", int'(stall_o[0]), 0);
    idle(4);

    // FLAG_LAT=2: freeze for 4 cycles in the middle of a stall
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("pre-freeze stall", int'(stall_o[2]), 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      settle();
      checkOutput("freeze pend_cnt", int'(pend_o[2]), 1);
      checkOutput("freeze stall", int'(stall_o[2]), 0);
      checkOutput("freeze issue", int'(issue_o[2]), 0);
    end
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("post-freeze stall", int'(stall_o[2]), 1);
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("post-freeze issue", int'(issue_o[2]), 1);
    checkOutput("post-freeze exec_en", int'(exec_o[2]), 1);
    idle(6);

    // Reset in the middle of FLUSH with writers in flight
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("b with s taken", int'(br_o[2]), 1);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    checkOutput("mid-flush pend_cnt", int'(pend_o[2]), 2);
    checkOutput("mid-flush if_flush", int'(flush_o[2]), 1);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    checkOutput("rst cycle if_flush", int'(flush_o[2]), 0);
    checkOutput("rst cycle issue", int'(issue_o[2]), 0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    checkOutput("after rst issue", int'(issue_o[2]), 1);
    checkOutput("after rst pend_cnt", int'(pend_o[2]), 0);
    checkOutput("after rst if_flush", int'(flush_o[2]), 0);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 1) != 0) ? 4'hE : 4'($urandom_range(0, 15));
      s   = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 7) == 0);
      cp  = ($urandom_range(0, 1) != 0);
      frz = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 99) == 0);
      applyStimulus(v, c, s, br, cp, frz, r);
    end

    idle(3);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
